// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM pipeline stage: FSM states, writeback select codes, timeout default.
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage_wb_select.sv
// Combinational writeback mux: ALU result, memory read data or link value.
module wb_select
    import mem_stage_pkg::*;
(
    input  logic [1:0]  mem_to_reg,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_data,
    input  logic [31:0] pc_plus4,
    output logic [31:0] data
);

    always_comb begin
        data = alu_result;
        case (wb_sel_e'(mem_to_reg))
            WB_MEM:  data = mem_data;
            WB_PC4:  data = pc_plus4;
            default: data = alu_result;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues aligned loads/stores to data memory, stalls until ack or timeout.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         alu_result,
    input  logic [31:0]         write_data,
    input  logic [31:0]         pc_plus4,
    input  logic [4:0]          dest_reg,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                reg_write,
    input  logic [1:0]          mem_to_reg,
    mem_access_stage_if.master  dmem,
    output logic                stall,
    output logic                wb_reg_write,
    output logic [4:0]          wb_dest_reg,
    output logic [31:0]         wb_data,
    output logic                mem_err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e        state;
    logic [CW-1:0] wait_cnt;
    logic          mem_op;
    logic          aligned;
    logic          at_limit;
    logic [31:0]   sel_data;

    assign mem_op   = mem_read | mem_write;
    assign aligned  = (alu_result[1:0] == 2'b00);
    assign at_limit = (wait_cnt == CW'(TIMEOUT - 1));

    wb_select u_wb_select (
        .mem_to_reg (mem_to_reg),
        .alu_result (alu_result),
        .mem_data   (dmem.dmem_rdata),
        .pc_plus4   (pc_plus4),
        .data       (sel_data)
    );

    always_comb begin
        stall = 1'b0;
        if (state == IDLE) stall = mem_op & aligned;
        else               stall = ~dmem.dmem_ack & ~at_limit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            wb_reg_write    <= 1'b0;
            wb_dest_reg     <= '0;
            wb_data         <= '0;
            mem_err         <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mem_op) begin
                        wb_reg_write <= reg_write;
                        wb_dest_reg  <= dest_reg;
                        wb_data      <= sel_data;
                    end else if (aligned) begin
                        state           <= ACCESS;
                        wait_cnt        <= '0;
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= mem_write;
                        dmem.dmem_addr  <= alu_result;
                        dmem.dmem_wdata <= write_data;
                        wb_reg_write    <= 1'b0;
                    end else begin
                        wb_reg_write <= 1'b0;
                        mem_err      <= 1'b1;
                    end
                end
                ACCESS: begin
                    // Ack is checked before the limit so a last-cycle ack completes normally.
                    if (dmem.dmem_ack) begin
                        state         <= IDLE;
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                        wb_reg_write  <= reg_write;
                        wb_dest_reg   <= dest_reg;
                        wb_data       <= sel_data;
                    end else if (at_limit) begin
                        state         <= IDLE;
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                        wb_reg_write  <= 1'b0;
                        wb_data       <= '0;
                        mem_err       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized checks of mem_access_stage against a transaction-level model.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int TB_TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] alu_result, write_data, pc_plus4;
    logic [4:0]  dest_reg;
    logic        mem_read, mem_write, reg_write;
    logic [1:0]  mem_to_reg;
    logic        stall, wb_reg_write, mem_err;
    logic [4:0]  wb_dest_reg;
    logic [31:0] wb_data;

    int compared   = 0;
    int mismatched = 0;

    mem_access_stage_if dmem_bus ();

    mem_access_stage #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clock        (clock),
        .reset        (reset),
        .alu_result   (alu_result),
        .write_data   (write_data),
        .pc_plus4     (pc_plus4),
        .dest_reg     (dest_reg),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .dmem         (dmem_bus.master),
        .stall        (stall),
        .wb_reg_write (wb_reg_write),
        .wb_dest_reg  (wb_dest_reg),
        .wb_data      (wb_data),
        .mem_err      (mem_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Writeback value chosen by the select code; reserved code behaves as ALU.
    function automatic logic [31:0] wb_model(input logic [1:0] sel, input logic [31:0] alu,
                                             input logic [31:0] mem, input logic [31:0] pc);
        if (sel == 2'b01) return mem;
        if (sel == 2'b10) return pc;
        return alu;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic rw, input logic [1:0] m2r,
                         input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc);
        mem_read   = rd;
        mem_write  = wr;
        reg_write  = rw;
        mem_to_reg = m2r;
        dest_reg   = dest;
        alu_result = alu;
        write_data = wd;
        pc_plus4   = pc;
    endtask

    task automatic drive_nop;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // One EX/MEM instruction; ack_after = ACCESS cycles without ack before the ack (>= TIMEOUT: never).
    task automatic txn(input string name, input logic rd, input logic wr, input logic rw,
                       input logic [1:0] m2r, input logic [4:0] dest, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc, input int ack_after,
                       input logic [31:0] rdata);
        logic is_mem, aligned, acked;
        is_mem  = rd | wr;
        aligned = (alu[1:0] == 2'b00);
        acked   = 1'b0;
        @(negedge clock);
        drive(rd, wr, rw, m2r, dest, alu, wd, pc);
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = $urandom;
        #1;
        chk({name, ".idle_stall"}, 32'(stall), 32'(is_mem && aligned));
        chk({name, ".idle_err"}, 32'(mem_err), 32'd0);
        chk({name, ".idle_req"}, 32'(dmem_bus.dmem_req), 32'd0);
        if (is_mem && aligned) begin
            for (int k = 0; k < TB_TIMEOUT; k++) begin
                @(negedge clock);
                dmem_bus.dmem_ack   = (k == ack_after);
                dmem_bus.dmem_rdata = (k == ack_after) ? rdata : $urandom;
                #1;
                chk({name, ".req"}, 32'(dmem_bus.dmem_req), 32'd1);
                chk({name, ".we"}, 32'(dmem_bus.dmem_we), 32'(wr));
                chk({name, ".addr"}, dmem_bus.dmem_addr, alu);
                chk({name, ".wdata"}, dmem_bus.dmem_wdata, wd);
                chk({name, ".bubble"}, 32'(wb_reg_write), 32'd0);
                chk({name, ".acc_stall"}, 32'(stall),
                    32'((k != ack_after) && (k != TB_TIMEOUT - 1)));
                if (k == ack_after) begin
                    acked = 1'b1;
                    break;
                end
            end
        end
        @(negedge clock);
        dmem_bus.dmem_ack = 1'b0;
        drive_nop();
        #1;
        chk({name, ".done_stall"}, 32'(stall), 32'd0);
        chk({name, ".done_req"}, 32'(dmem_bus.dmem_req), 32'd0);
        if (!is_mem || acked) begin
            chk({name, ".wb_rw"}, 32'(wb_reg_write), 32'(rw));
            chk({name, ".wb_dest"}, 32'(wb_dest_reg), 32'(dest));
            chk({name, ".wb_data"}, wb_data, wb_model(m2r, alu, rdata, pc));
            chk({name, ".err"}, 32'(mem_err), 32'd0);
        end else if (!aligned) begin
            chk({name, ".mis_rw"}, 32'(wb_reg_write), 32'd0);
            chk({name, ".mis_err"}, 32'(mem_err), 32'd1);
        end else begin
            chk({name, ".to_rw"}, 32'(wb_reg_write), 32'd0);
            chk({name, ".to_data"}, wb_data, 32'd0);
            chk({name, ".to_err"}, 32'(mem_err), 32'd1);
        end
    endtask

    initial begin
        logic        r_rd, r_wr, r_rw;
        logic [1:0]  r_m2r;
        logic [31:0] r_alu;
        int          r_ack;

        reset = 1'b1;
        drive_nop();
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = '0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst.req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rst.we", 32'(dmem_bus.dmem_we), 32'd0);
        chk("rst.addr", dmem_bus.dmem_addr, 32'd0);
        chk("rst.wdata", dmem_bus.dmem_wdata, 32'd0);
        chk("rst.wb_rw", 32'(wb_reg_write), 32'd0);
        chk("rst.wb_dest", 32'(wb_dest_reg), 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        chk("rst.err", 32'(mem_err), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        reset = 1'b0;

        txn("alu", 1'b0, 1'b0, 1'b1, 2'b00, 5'd5, 32'h10, 32'h0, 32'h44, 0, 32'h0);
        txn("link", 1'b0, 1'b0, 1'b1, 2'b10, 5'd31, 32'h77, 32'h0, 32'h1004, 0, 32'h0);
        txn("rsvd", 1'b0, 1'b0, 1'b1, 2'b11, 5'd9, 32'hCAFE, 32'h0, 32'h2000, 0, 32'h0);
        txn("load", 1'b1, 1'b0, 1'b1, 2'b01, 5'd7, 32'h100, 32'h0, 32'h0, 3, 32'hDEADBEEF);
        txn("store", 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 32'h200, 32'h1234, 32'h0, 2, 32'h0);
        txn("rdwr", 1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 32'h204, 32'h55AA, 32'h0, 0, 32'h0);
        txn("misal", 1'b1, 1'b0, 1'b1, 2'b01, 5'd3, 32'h102, 32'h0, 32'h0, 0, 32'h0);
        txn("ack_lim", 1'b1, 1'b0, 1'b1, 2'b01, 5'd4, 32'h300, 32'h0, 32'h0, TB_TIMEOUT - 1,
            32'h600DF00D);
        txn("tmo", 1'b1, 1'b0, 1'b1, 2'b01, 5'd6, 32'h400, 32'h0, 32'h0, TB_TIMEOUT + 4,
            32'h0);

        // Late ack for the aborted request arrives while idle and must be ignored.
        @(negedge clock);
        dmem_bus.dmem_ack = 1'b1;
        @(negedge clock);
        dmem_bus.dmem_ack = 1'b0;
        #1;
        chk("late_ack.req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("late_ack.err", 32'(mem_err), 32'd0);
        chk("late_ack.wb_rw", 32'(wb_reg_write), 32'd0);
        chk("late_ack.stall", 32'(stall), 32'd0);

        // Reset during the second ACCESS cycle.
        txn("pre_rst", 1'b0, 1'b0, 1'b1, 2'b00, 5'd12, 32'hABCD, 32'h0, 32'h0, 0, 32'h0);
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b1, 2'b01, 5'd8, 32'h500, 32'h0, 32'h0);
        @(negedge clock);
        #1;
        chk("mid_rst.req1", 32'(dmem_bus.dmem_req), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        drive_nop();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst.req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("mid_rst.we", 32'(dmem_bus.dmem_we), 32'd0);
        chk("mid_rst.addr", dmem_bus.dmem_addr, 32'd0);
        chk("mid_rst.wb_dest", 32'(wb_dest_reg), 32'd0);
        chk("mid_rst.wb_data", wb_data, 32'd0);
        chk("mid_rst.wb_rw", 32'(wb_reg_write), 32'd0);
        chk("mid_rst.err", 32'(mem_err), 32'd0);
        chk("mid_rst.stall", 32'(stall), 32'd0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(2, 0))
                0: begin r_rd = 1'b0; r_wr = 1'b0; end
                1: begin r_rd = 1'b1; r_wr = 1'b0; end
                default: begin r_rd = 1'b0; r_wr = 1'b1; end
            endcase
            r_rw  = 1'($urandom);
            r_m2r = 2'($urandom);
            if (!r_rd && !r_wr && r_m2r == 2'b01) r_m2r = 2'b10;
            r_alu = $urandom;
            if ($urandom_range(3, 0) != 0) r_alu[1:0] = 2'b00;
            r_ack = ($urandom_range(7, 0) == 0) ? TB_TIMEOUT + 1 : int'($urandom_range(6, 0));
            txn("rnd", r_rd, r_wr, r_rw, r_m2r, 5'($urandom), r_alu, $urandom, $urandom,
                r_ack, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
